// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard detector and trap sequencer.
// Tracks in-flight load destinations and stalls dependent instructions.
// Sequences branch flushes and the ECALL drain-then-trap redirect.
// Counts stall cycles for performance debug.
module hazard_ctrl #(
  parameter int NREG         = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_wen,
  input  logic             id_is_load,
  input  logic             id_is_ecall,
  input  logic             br_jmp_flag,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic             wb_is_load,
  output logic             stall_flag,
  output logic             flush_id,
  output logic             trap_req,
  output logic [31:0]      trap_pc,
  output logic [NREG-1:0]  sb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Drain counter must hold DRAIN_CYCLES; keep at least one bit.
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DW-1:0]     r_drain_cnt;
  logic [DW-1:0]     w_drain_cnt_next;
  logic [DW-1:0]     w_drain_dec;
  logic              w_capture;
  logic              w_stall;
  logic              w_flush;
  logic              r_trap_req;
  logic [31:0]       r_trap_pc;
  logic [NREG-1:0]   r_sb_busy;
  logic [NREG-1:0]   w_sb_next;
  logic [NREG-1:0]   w_set_mask;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_busy_eff;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_sb_set;
  logic              w_sb_clr;
  logic              w_issue;
  logic              w_haz_rs1;
  logic              w_haz_rs2;
  logic              w_haz_rd;
  logic              w_hazard;

  // Issue only when the instruction really leaves ID this cycle; ECALL
  // never issues, it is consumed by the trap flow instead.
  assign w_issue  = id_valid & ~br_jmp_flag & ~stall_flag &
                    (r_state == IDLE) & ~id_is_ecall;
  assign w_sb_set = w_issue & id_is_load & id_rd_wen & (id_rd != 5'd0);
  assign w_sb_clr = wb_we & wb_is_load & (wb_addr != 5'd0);

  // One-hot set/clear masks per scoreboard bit.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb_mask
      assign w_set_mask[gi] = w_sb_set & (id_rd == 5'(gi));
      assign w_clr_mask[gi] = w_sb_clr & (wb_addr == 5'(gi));
    end
  endgenerate

  // A load being written back this cycle no longer blocks its consumer.
  assign w_busy_eff = r_sb_busy & ~w_clr_mask;
  // Set wins over clear when both target the same register.
  assign w_sb_next  = (r_sb_busy & ~w_clr_mask) | w_set_mask;

  assign w_haz_rs1 = id_rs1_used & (id_rs1 != 5'd0) & w_busy_eff[id_rs1];
  assign w_haz_rs2 = id_rs2_used & (id_rs2 != 5'd0) & w_busy_eff[id_rs2];
  assign w_haz_rd  = id_rd_wen   & (id_rd  != 5'd0) & w_busy_eff[id_rd];
  assign w_hazard  = id_valid & (w_haz_rs1 | w_haz_rs2 | w_haz_rd);

  assign w_drain_dec = (r_drain_cnt == '0) ? '0 : (r_drain_cnt - DW'(1));

  // Next-state and stall/flush decode; a taken branch overrides everything.
  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    w_capture        = 1'b0;
    w_stall          = 1'b0;
    w_flush          = 1'b0;
    case (r_state)
      IDLE: begin
        if (br_jmp_flag) begin
          w_flush = 1'b1;
        end else if (w_hazard) begin
          w_stall = 1'b1;
        end else if (id_valid & id_is_ecall) begin
          w_capture        = 1'b1;
          w_drain_cnt_next = DW'(DRAIN_CYCLES);
          w_state_next     = DRAIN;
          w_stall          = 1'b1;
        end
      end
      DRAIN: begin
        if (br_jmp_flag) begin
          // Older branch resolved: the ECALL was on the wrong path.
          w_flush          = 1'b1;
          w_drain_cnt_next = '0;
          w_state_next     = IDLE;
        end else begin
          w_stall          = 1'b1;
          w_drain_cnt_next = w_drain_dec;
          if ((w_drain_dec == '0) && (r_sb_busy == '0)) begin
            w_state_next = TRAP;
          end
        end
      end
      TRAP: begin
        w_flush      = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Keep stall/flush quiet while reset is held, regardless of inputs.
  assign stall_flag = w_stall & rst_n;
  assign flush_id   = w_flush & rst_n;

  // FSM state, drain counter and the registered trap request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_drain_cnt <= '0;
      r_trap_req  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
      r_trap_req  <= (w_state_next == TRAP);
    end
  end

  // Capture the ECALL PC as the mepc value; held until the next ECALL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap_pc <= 32'd0;
    end else if (w_capture) begin
      r_trap_pc <= id_pc;
    end
  end

  // Pending-load scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_busy <= '0;
    end else begin
      r_sb_busy <= w_sb_next;
    end
  end

  // Free-running stall-cycle counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_flag) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign trap_req  = r_trap_req;
  assign trap_pc   = r_trap_pc;
  assign sb_busy   = r_sb_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
